// File: rtl/program_loader.sv
// Byte-stream instruction loader: assembles big-endian 16-bit words and writes them to imem.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        rx_ready_o,
   output logic [15:0] data_in_o,
   output logic [7:0]  inst_add_o,
   output logic        isntruction_wenable_o,
   output logic        loading_o,
   output logic        done_o,
   output logic        error_o
);

   typedef enum logic [2:0] {
      StIdle, StHdr, StHi, StLo, StWr, StChk, StDone, StError
   } state_e;

   state_e      state_q, state_d;
   logic [8:0]  len_q, len_d;
   logic [8:0]  cnt_q, cnt_d;
   logic [15:0] data_q, data_d;
   logic [7:0]  addr_q, addr_d;
   logic        accept;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif

   assign accept = rx_valid_i & rx_ready_o;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      addr_d  = addr_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start_i) state_d = StHdr;
         end
         StHdr: begin
            if (accept) begin
               // A header of zero encodes a full 256-word image.
               len_d   = (rx_data_i == 8'd0) ? 9'd256 : {1'b0, rx_data_i};
               cnt_d   = 9'd0;
               addr_d  = 8'd0;
`ifdef LOADER_CHECKSUM_EN
               csum_d  = rx_data_i;
`endif
               state_d = StHi;
            end
         end
         StHi: begin
            if (accept) begin
               data_d[15:8] = rx_data_i;
`ifdef LOADER_CHECKSUM_EN
               csum_d       = csum_q ^ rx_data_i;
`endif
               state_d      = StLo;
            end
         end
         StLo: begin
            if (accept) begin
               data_d[7:0] = rx_data_i;
`ifdef LOADER_CHECKSUM_EN
               csum_d      = csum_q ^ rx_data_i;
`endif
               state_d     = StWr;
            end
         end
         StWr: begin
            addr_d = addr_q + 8'd1;
            cnt_d  = cnt_q + 9'd1;
            if (cnt_q + 9'd1 == len_q) begin
`ifdef LOADER_CHECKSUM_EN
               state_d = StChk;
`else
               state_d = StDone;
`endif
            end else begin
               state_d = StHi;
            end
         end
         StChk: begin
`ifdef LOADER_CHECKSUM_EN
            if (accept) state_d = (rx_data_i == csum_q) ? StDone : StError;
`else
            state_d = StIdle;
`endif
         end
         StDone, StError: begin
            if (start_i) state_d = StHdr;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         len_q   <= 9'd0;
         cnt_q   <= 9'd0;
         data_q  <= 16'd0;
         addr_q  <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   // Outputs decode from state only; no path from rx_valid/rx_data to rx_ready.
   assign rx_ready_o            = (state_q == StHdr) || (state_q == StHi) ||
                                  (state_q == StLo)  || (state_q == StChk);
   assign isntruction_wenable_o = (state_q == StWr);
   assign loading_o             = rx_ready_o || (state_q == StWr);
   assign done_o                = (state_q == StDone);
   assign data_in_o             = data_q;
   assign inst_add_o            = addr_q;
`ifdef LOADER_CHECKSUM_EN
   assign error_o               = (state_q == StError);
`else
   assign error_o               = 1'b0;
`endif

endmodule

// File: doc/program_loader.md
# program_loader

Writer side of the instruction-memory load port. Accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words big-endian, and drives the instruction memory's write data, write address and write enable one word per write cycle. While loading it holds `loading` high so the top level steers the memory address from the load port instead of the PC. When loading completes it raises `done` to release the CPU.

## Interface
- No parameters. Memory depth is fixed at 256 words by the 8-bit address.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- `rx_data` input 8: incoming byte.
- `rx_valid` input 1: `rx_data` is valid.
- `rx_ready` output 1: loader accepts a byte this cycle.
- `data_in` output 16: instruction word to the memory.
- `inst_add` output 8: instruction memory write address.
- `isntruction_wenable` output 1: memory write enable, one cycle per word.
- `loading` output 1: a load is in progress.
- `done` output 1: last load completed successfully; held until the next `start` or `reset`.
- `error` output 1: last load failed its checksum; held until the next `start` or `reset`.

## Operation
- Stream format:
  - Header byte N: word count. N = 0 means 256 words.
  - Then 2·N data bytes, sent as high byte then low byte for each word.
  - Then one checksum byte, present only when `LOADER_CHECKSUM_EN` is defined.
- A byte is accepted on a rising edge where `rx_valid & rx_ready` is 1. `rx_data` is ignored at all other times.
- States:
  - IDLE: `rx_ready` = 0. `start` → HDR.
  - HDR: `rx_ready` = 1. Accept → latch N, clear word counter to 0 and address to 0, go to HI.
  - HI: `rx_ready` = 1. Accept → latch `data_in[15:8]`, go to LO.
  - LO: `rx_ready` = 1. Accept → latch `data_in[7:0]`, go to WR.
  - WR: `rx_ready` = 0; `isntruction_wenable` = 1 for exactly this cycle with the current `inst_add` and `data_in`. On exit, `inst_add` increments (8-bit wrap) and the counter increments. If this was word N (256 when N = 0): go to CHK if the macro is defined, else DONE. Otherwise go to HI.
  - CHK: `rx_ready` = 1. Accept → compare the byte with the running XOR. Match → DONE; mismatch → ERROR.
  - DONE: `done` = 1. `start` → HDR.
  - ERROR: `error` = 1. `start` → HDR.
- `loading` = 1 in HDR, HI, LO, WR and CHK; 0 otherwise.
- `start` during HDR, HI, LO, WR or CHK is ignored.
- A `start` that leaves DONE or ERROR clears `done` and `error` on that same edge.
- Running checksum is the XOR of the header byte and every data byte, cleared on entry to HDR.
- Memory contents beyond the last loaded word are not touched.

## Timing
- Reset values: `rx_ready` = 0, `isntruction_wenable` = 0, `inst_add` = 0, `data_in` = 0, `loading` = 0, `done` = 0, `error` = 0. State = IDLE, counter and checksum = 0.
- `reset` mid-load returns to IDLE on the next edge, discards any partial word, and issues no further write. Words already written stay in memory.
- All outputs are registered or decoded from the state register only. There is no combinational path from `rx_valid` or `rx_data` to `rx_ready`.
- `isntruction_wenable` rises on the edge that accepts the low byte and falls one cycle later.
- `data_in` and `inst_add` are stable throughout the write cycle.
- Minimum cost per word is 3 cycles (HI, LO, WR) when `rx_valid` is held high.
- Stalls: `rx_valid` low in HDR, HI, LO or CHK holds the state indefinitely; there is no timeout.
- `done` rises on the edge after the last WR (no checksum) or after checksum acceptance.
- The 256th word is written at `inst_add` = 0xFF. The address then wraps to 0x00, and no write to 0x00 follows.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - The CHK state and the checksum register exist.
  - A mismatch drives `error` = 1 with `done` = 0.
- `LOADER_CHECKSUM_EN` undefined:
  - No checksum byte is expected; WR for the last word goes directly to DONE.
  - `error` is tied to 0 and the ERROR state is unreachable.

## Test plan
- Reset, `start`, stream 0x02, 0x12, 0x34, 0xAB, 0xCD → writes 0x1234 @ 0x00 and 0xABCD @ 0x01, one `isntruction_wenable` pulse each. `done` = 1 and `loading` = 0 afterwards (macro off).
- Macro on, stream 0x01, 0xA5, 0x0F, checksum 0xAB (0x01 ^ 0xA5 ^ 0x0F) → `done` = 1. Same stream with checksum 0x00 → `error` = 1, `done` = 0.
- Header 0x00, 512 data bytes with word i = {i, ~i} → exactly 256 writes, last at 0xFF with value 0xFF00, no write after it, `done` = 1.
- Gap `rx_valid` low for 5 cycles between a high and low byte → `rx_ready` stays 1, no write during the gap, word 0x1234 still written intact.
- Assert `reset` for one cycle in LO after high byte 0x77 → all outputs 0 next cycle and no write. A fresh `start` load of 0x01, 0x00, 0x01 writes 0x0001 @ 0x00.
- Pulse `start` while in HI → ignored; the load continues. Pulse `start` in DONE → `done` clears and `rx_ready` = 1 next cycle.
